acc_dma_streamer: RTL and testbench

Memory-side streaming engine that feeds the accelerator top through its `ready`/`data_in` load port and collects its `valid`/`ofmap` results. On `start` it fetches `rd_words` 32-bit words from memory and presents them one per cycle on `acc_data` with `acc_ready`. It captures every result word into a buffer and writes the results back to memory from `wr_base`. It reports `finished` once the accelerator asserts `acc_done` and all results have been written.

---
 rtl/acc_dma_pkg.sv | 15 +
 rtl/sync_fifo.sv | 76 +++++++
 rtl/acc_dma_streamer.sv | 184 ++++++++++++++++++
 tb/tb_acc_dma_streamer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_dma_pkg.sv
// Shared types and constants for the accelerator DMA streamer.
package acc_dma_pkg;

    localparam int WORD_BYTES = 4;
    localparam int DATA_W     = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_FIN
    } dma_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with registered storage; push-to-head latency 1 cycle (no fall-through).
// Backpressure: push is refused when full unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head_dat
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed once counted valid.
    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];

endmodule

// File: rtl/acc_dma_streamer.sv
// Streams rd_words memory words into the accelerator load port and writes its results back from wr_base.
// Start->first read request 1 cycle; read/write grants stall transfers, a full result buffer drops words (sticky overflow).
module acc_dma_streamer
    import acc_dma_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [CNT_W-1:0]  rd_words,
    input  logic [ADDR_W-1:0] wr_base,
    output logic              busy,
    output logic              finished,
    output logic              overflow,
    output logic [CNT_W-1:0]  out_count,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_gnt,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              acc_ready,
    output logic [DATA_W-1:0] acc_data,
    input  logic              acc_valid,
    input  logic [DATA_W-1:0] acc_ofmap,
    input  logic              acc_done,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_wr_gnt
);

    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    dma_state_e        state_q, state_d;
    logic [CNT_W-1:0]  words_q, words_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [CNT_W-1:0]  fed_q, fed_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              overflow_q, overflow_d;

    logic              launch, rd_acc, rd_rsp, feed, cap, cap_ok, wr_acc, wf_drained;
    logic [CNT_W:0]    inflight;
    logic              rf_full, rf_empty, wf_full, wf_empty;
    logic [FCW-1:0]    rf_count, wf_count;
    logic [DATA_W-1:0] rf_head, wf_head;

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (launch),
        .push     (rd_rsp),
        .push_dat (mem_rd_data),
        .pop      (feed),
        .full     (rf_full),
        .empty    (rf_empty),
        .count    (rf_count),
        .head_dat (rf_head)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (launch),
        .push     (cap),
        .push_dat (acc_ofmap),
        .pop      (wr_acc),
        .full     (wf_full),
        .empty    (wf_empty),
        .count    (wf_count),
        .head_dat (wf_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            words_q       <= '0;
            issued_q      <= '0;
            fed_q         <= '0;
            outstanding_q <= '0;
            out_count_q   <= '0;
            rd_addr_q     <= '0;
            wr_addr_q     <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            words_q       <= words_d;
            issued_q      <= issued_d;
            fed_q         <= fed_d;
            outstanding_q <= outstanding_d;
            out_count_q   <= out_count_d;
            rd_addr_q     <= rd_addr_d;
            wr_addr_q     <= wr_addr_d;
            overflow_q    <= overflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (launch) state_d = (rd_words == '0) ? ST_RUN : ST_LOAD;
            ST_LOAD:  if (feed && (fed_q + CNT_W'(1) == words_q)) state_d = ST_RUN;
            ST_RUN:   if (acc_done) state_d = ST_DRAIN;
            ST_DRAIN: if (wf_drained) state_d = ST_FIN;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Read credit covers both in-flight responses and words parked in the read FIFO.
    always_comb begin
        launch      = (state_q == ST_IDLE) && start;
        busy        = (state_q != ST_IDLE);
        finished    = (state_q == ST_FIN);
        inflight    = {1'b0, outstanding_q} + (CNT_W+1)'(rf_count);
        mem_rd_req  = (state_q == ST_LOAD) && (issued_q < words_q) && !rf_full &&
                      (inflight < (CNT_W+1)'(FIFO_DEPTH));
        mem_rd_addr = rd_addr_q;
        rd_acc      = mem_rd_req && mem_rd_gnt;
        rd_rsp      = mem_rd_valid && (state_q != ST_IDLE);
        acc_ready   = (state_q == ST_LOAD) && !rf_empty;
        acc_data    = acc_ready ? rf_head : '0;
        feed        = acc_ready;
        mem_wr_req  = !wf_empty;
        mem_wr_addr = wr_addr_q;
        mem_wr_data = mem_wr_req ? wf_head : '0;
        wr_acc      = mem_wr_req && mem_wr_gnt;
        cap         = acc_valid && ((state_q == ST_LOAD) || (state_q == ST_RUN) ||
                                    (state_q == ST_DRAIN));
        cap_ok      = cap && (!wf_full || wr_acc);
        wf_drained  = !cap_ok && (wf_empty || ((wf_count == FCW'(1)) && wr_acc));
        overflow    = overflow_q;
        out_count   = out_count_q;
    end

    always_comb begin
        words_d       = words_q;
        issued_d      = issued_q;
        fed_d         = fed_q;
        outstanding_d = outstanding_q;
        out_count_d   = out_count_q;
        rd_addr_d     = rd_addr_q;
        wr_addr_d     = wr_addr_q;
        overflow_d    = overflow_q;
        if (launch) begin
            words_d       = rd_words;
            issued_d      = '0;
            fed_d         = '0;
            outstanding_d = '0;
            out_count_d   = '0;
            rd_addr_d     = rd_base;
            wr_addr_d     = wr_base;
            overflow_d    = 1'b0;
        end else begin
            if (rd_acc) begin
                issued_d  = issued_q + CNT_W'(1);
                rd_addr_d = rd_addr_q + ADDR_W'(WORD_BYTES);
            end
            if (rd_acc && !rd_rsp) begin
                outstanding_d = outstanding_q + CNT_W'(1);
            end else if (!rd_acc && rd_rsp) begin
                outstanding_d = outstanding_q - CNT_W'(1);
            end
            if (feed) begin
                fed_d = fed_q + CNT_W'(1);
            end
            if (wr_acc) begin
                wr_addr_d = wr_addr_q + ADDR_W'(WORD_BYTES);
            end
            if (cap_ok) begin
                out_count_d = out_count_q + CNT_W'(1);
            end else if (cap) begin
                overflow_d = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_acc_dma_streamer.sv
// Scoreboard bench for acc_dma_streamer: memory/grant models in background, directed jobs in the main thread.
module tb_acc_dma_streamer;
    import acc_dma_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] rd_base, wr_base;
    logic [15:0] rd_words;
    logic        busy, finished, overflow;
    logic [15:0] out_count;
    logic        mem_rd_req, mem_rd_gnt, mem_rd_valid;
    logic [31:0] mem_rd_addr, mem_rd_data;
    logic        acc_ready, acc_valid, acc_done;
    logic [31:0] acc_data, acc_ofmap;
    logic        mem_wr_req, mem_wr_gnt;
    logic [31:0] mem_wr_addr, mem_wr_data;

    acc_dma_streamer #(.FIFO_DEPTH(4), .ADDR_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rd_base(rd_base), .rd_words(rd_words), .wr_base(wr_base),
        .busy(busy), .finished(finished), .overflow(overflow), .out_count(out_count),
        .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_gnt(mem_rd_gnt),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .acc_ready(acc_ready), .acc_data(acc_data),
        .acc_valid(acc_valid), .acc_ofmap(acc_ofmap), .acc_done(acc_done),
        .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_gnt(mem_wr_gnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        logic [31:0] dat;
    } rsp_t;

    logic [31:0] img [16];
    logic [31:0] img_base;
    rsp_t        rsp_q[$];
    int          rd_lat, rd_gmode, outst, max_outst, rd_req_cycles;
    logic [31:0] exp_feed[$];
    int          feed_cyc[$];
    logic [63:0] exp_wr[$];
    int          wmode, wwait, last_wr_cyc;
    int          fin_cnt, fin_cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    // Memory read model: in-order responses rd_lat cycles after acceptance.
    initial begin
        mem_rd_valid = 1'b0;
        mem_rd_data  = '0;
        mem_rd_gnt   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rsp_q.delete();
                outst = 0;
            end else begin
                if (mem_rd_req) rd_req_cycles++;
                if (mem_rd_req && mem_rd_gnt) begin
                    rsp_q.push_back('{cyc + rd_lat, img[4'((mem_rd_addr - img_base) >> 2)]});
                    outst++;
                    if (outst > max_outst) max_outst = outst;
                end
                if (mem_rd_valid) begin
                    void'(rsp_q.pop_front());
                    outst--;
                end
            end
            @(posedge clk);
            #2;
            mem_rd_valid = (rsp_q.size() != 0) && (rsp_q[0].due <= cyc);
            mem_rd_data  = mem_rd_valid ? rsp_q[0].dat : '0;
            mem_rd_gnt   = (rd_gmode == 0) ? 1'b1 : ~mem_rd_gnt;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst && acc_ready) begin
            feed_cyc.push_back(cyc);
            if (exp_feed.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL acc_feed_extra: got 0x%0h, expected no word", acc_data);
            end else begin
                check("acc_data", {32'h0, acc_data}, {32'h0, exp_feed.pop_front()});
            end
        end
    end

    // Write model: mode 0 always grants, 1 never, 2 grants after a request waits 2 cycles.
    initial begin
        mem_wr_gnt = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                wwait = 0;
            end else if (mem_wr_req && mem_wr_gnt) begin
                if (exp_wr.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL mem_wr_extra: got addr 0x%0h data 0x%0h, expected no write", mem_wr_addr, mem_wr_data);
                end else begin
                    check("mem_wr addr/data", {mem_wr_addr, mem_wr_data}, exp_wr.pop_front());
                end
                last_wr_cyc = cyc;
                wwait = 0;
            end else if (mem_wr_req) begin
                wwait++;
            end
            @(posedge clk);
            #2;
            case (wmode)
                0:       mem_wr_gnt = 1'b1;
                1:       mem_wr_gnt = 1'b0;
                default: mem_wr_gnt = (wwait >= 2);
            endcase
        end
    end

    initial forever begin
        @(negedge clk);
        if (finished) begin
            fin_cnt++;
            fin_cyc = cyc;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [31:0] rb, input logic [15:0] n, input logic [31:0] wb);
        rd_base  = rb;
        rd_words = n;
        wr_base  = wb;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic pulse_done();
        acc_done = 1'b1;
        tick();
        acc_done = 1'b0;
    endtask

    task automatic wait_feed(input int budget, input string name);
        int n = 0;
        while (exp_feed.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_feed.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s feed timeout: %0d words still expected after %0d cycles", name, exp_feed.size(), budget);
        end
    endtask

    task automatic wait_fin(input int f0, input int budget, input string name);
        int n = 0;
        while (fin_cnt == f0 && n < budget) begin
            tick();
            n++;
        end
        if (fin_cnt == f0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s finish timeout: no finished pulse within %0d cycles", name, budget);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_finished"}, finished, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_out_count"}, out_count, 0);
        check({tag, "_mem_rd_req"}, mem_rd_req, 0);
        check({tag, "_mem_wr_req"}, mem_wr_req, 0);
        check({tag, "_acc_ready"}, acc_ready, 0);
        check({tag, "_acc_data"}, acc_data, 0);
        check({tag, "_mem_rd_addr"}, mem_rd_addr, 0);
        check({tag, "_mem_wr_addr"}, mem_wr_addr, 0);
        check({tag, "_mem_wr_data"}, mem_wr_data, 0);
    endtask

    initial begin
        int f0, rq0;
        rst = 1'b1; start = 1'b0; rd_base = '0; wr_base = '0; rd_words = '0;
        acc_valid = 1'b0; acc_ofmap = '0; acc_done = 1'b0;
        img_base = '0; rd_lat = 1; rd_gmode = 0; outst = 0; max_outst = 0; rd_req_cycles = 0;
        wmode = 0; wwait = 0; last_wr_cyc = 0; fin_cnt = 0; fin_cyc = 0;
        for (int i = 0; i < 16; i++) img[i] = '0;

        // Reset state
        tick(3);
        @(negedge clk);
        check_reset_outputs("reset");
        tick();
        rst = 1'b0;
        tick(2);

        // Basic load: 3 words, latency 1, grant always high
        img_base = 32'h100; img[0] = 32'hA; img[1] = 32'hB; img[2] = 32'hC;
        exp_feed.push_back(32'hA); exp_feed.push_back(32'hB); exp_feed.push_back(32'hC);
        feed_cyc.delete();
        rd_lat = 1; rd_gmode = 0;
        f0 = fin_cnt;
        launch(32'h100, 16'd3, 32'h300);
        @(negedge clk);
        check("basic_busy_T1", busy, 1);
        check("basic_rd_req_T1", mem_rd_req, 1);
        check("basic_rd_addr_T1", mem_rd_addr, 32'h100);
        tick();
        wait_feed(50, "basic");
        check("basic_feed_count", feed_cyc.size(), 3);
        if (feed_cyc.size() == 3) check("basic_back_to_back", feed_cyc[2] - feed_cyc[0], 2);
        @(negedge clk);
        check("basic_run_ready", acc_ready, 0);
        check("basic_run_busy", busy, 1);
        check("basic_run_rd_req", mem_rd_req, 0);
        tick();
        pulse_done();
        wait_fin(f0, 20, "basic");

        // Throttled read: latency 3, toggling grant, early acc_done must be ignored
        img_base = 32'h400;
        for (int i = 0; i < 6; i++) begin
            img[i] = 32'hC0DE_0000 + i;
            exp_feed.push_back(32'hC0DE_0000 + i);
        end
        feed_cyc.delete();
        rd_lat = 3; rd_gmode = 1; max_outst = 0;
        f0 = fin_cnt;
        launch(32'h400, 16'd6, 32'h500);
        tick(2);
        pulse_done();
        wait_feed(200, "throttle");
        check("throttle_no_early_finish", fin_cnt, f0);
        check("throttle_busy", busy, 1);
        check("throttle_outst_bound", (max_outst <= 4), 1);
        if (feed_cyc.size() == 6) check("throttle_has_gaps", (feed_cyc[5] - feed_cyc[0] > 5), 1);
        pulse_done();
        wait_fin(f0, 20, "throttle");

        // Long latency: outstanding must saturate at exactly FIFO_DEPTH
        img_base = 32'h700;
        for (int i = 0; i < 8; i++) begin
            img[i] = 32'h7700_0000 + i;
            exp_feed.push_back(32'h7700_0000 + i);
        end
        rd_lat = 8; rd_gmode = 0; max_outst = 0;
        f0 = fin_cnt;
        launch(32'h700, 16'd8, 32'h800);
        wait_feed(300, "deep");
        check("deep_outst_peak", max_outst, 4);
        pulse_done();
        wait_fin(f0, 20, "deep");

        // Overflow: grant low, 6 results -> 4 kept; then push on full with write accepted
        for (int i = 0; i < 4; i++) exp_wr.push_back({32'h600 + 32'(4 * i), 32'h11 + 32'(i)});
        exp_wr.push_back({32'h610, 32'h17});
        wmode = 1;
        f0 = fin_cnt;
        launch(32'h0, 16'd0, 32'h600);
        for (int i = 0; i < 6; i++) begin
            acc_valid = 1'b1;
            acc_ofmap = 32'h11 + 32'(i);
            tick();
        end
        acc_valid = 1'b0;
        @(negedge clk);
        check("ovf_flag", overflow, 1);
        check("ovf_out_count", out_count, 4);
        check("ovf_wr_req", mem_wr_req, 1);
        tick();
        wmode = 0;
        acc_valid = 1'b1;
        acc_ofmap = 32'h17;
        tick();
        acc_valid = 1'b0;
        pulse_done();
        wait_fin(f0, 50, "overflow");
        check("ovf_out_count_final", out_count, 5);
        check("ovf_sticky", overflow, 1);
        check("ovf_writes_done", exp_wr.size(), 0);

        // Zero load: straight to RUN, no read request, start clears overflow
        f0 = fin_cnt;
        rq0 = rd_req_cycles;
        launch(32'h900, 16'd0, 32'h980);
        acc_done = 1'b1;
        @(negedge clk);
        check("zero_busy", busy, 1);
        check("zero_ovf_cleared", overflow, 0);
        check("zero_out_count_cleared", out_count, 0);
        check("zero_acc_ready", acc_ready, 0);
        tick();
        acc_done = 1'b0;
        @(negedge clk);
        check("zero_finished_T2", finished, 0);
        tick();
        @(negedge clk);
        check("zero_finished_T3", finished, 1);
        tick(2);
        check("zero_no_rd_req", rd_req_cycles - rq0, 0);
        check("zero_fin_once", fin_cnt - f0, 1);

        // Write-back: 5 results, each write granted after a 2-cycle wait
        for (int i = 0; i < 5; i++) exp_wr.push_back({32'h200 + 32'(4 * i), 32'(i + 1)});
        wmode = 2;
        f0 = fin_cnt;
        launch(32'h0, 16'd0, 32'h200);
        for (int i = 0; i < 5; i++) begin
            acc_valid = 1'b1;
            acc_ofmap = 32'(i + 1);
            tick();
        end
        acc_valid = 1'b0;
        pulse_done();
        wait_fin(f0, 100, "writeback");
        tick(3);
        check("wb_out_count", out_count, 5);
        check("wb_overflow", overflow, 0);
        check("wb_fin_after_last_write", fin_cyc - last_wr_cyc, 1);
        check("wb_fin_once", fin_cnt - f0, 1);
        check("wb_writes_done", exp_wr.size(), 0);
        wmode = 0;

        // Reset mid-job, then a clean job
        img_base = 32'h800;
        for (int i = 0; i < 8; i++) begin
            img[i] = 32'h8800_0000 + i;
            exp_feed.push_back(32'h8800_0000 + i);
        end
        rd_lat = 3; rd_gmode = 0;
        launch(32'h800, 16'd8, 32'hA00);
        tick(4);
        rst = 1'b1;
        exp_feed.delete();
        @(negedge clk);
        check_reset_outputs("midrst");
        tick();
        rst = 1'b0;
        tick(2);
        img_base = 32'h100; img[0] = 32'hA; img[1] = 32'hB; img[2] = 32'hC;
        exp_feed.push_back(32'hA); exp_feed.push_back(32'hB); exp_feed.push_back(32'hC);
        exp_wr.push_back({32'hB00, 32'h55});
        rd_lat = 1;
        f0 = fin_cnt;
        launch(32'h100, 16'd3, 32'hB00);
        wait_feed(50, "post_reset");
        acc_valid = 1'b1;
        acc_ofmap = 32'h55;
        tick();
        acc_valid = 1'b0;
        pulse_done();
        wait_fin(f0, 30, "post_reset");
        tick(2);
        check("post_reset_out_count", out_count, 1);
        check("post_reset_writes_done", exp_wr.size(), 0);
        check("post_reset_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
